// File: rtl/gsensor_pkg.sv
// Shared types and constants for the accelerometer SPI master: FSM states, header layout, ADXL345 registers.
package gsensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int HDR_RW = 7;
    localparam int HDR_MB = 6;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    function automatic logic [7:0] make_hdr(input logic rw, input logic mb, input logic [5:0] addr);
        logic [7:0] h;
        h         = {2'b00, addr};
        h[HDR_RW] = rw;
        h[HDR_MB] = mb;
        return h;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period tick generator: one fall/rise strobe every CLK_DIV clocks while enabled.
// Latency: first strobe (always a fall) CLK_DIV clocks after en rises; disabling rewinds to the high phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk_fall,
    output logic sclk_rise
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          phase_hi;
    logic          tick;

    assign tick      = en && (cnt == CW'(CLK_DIV - 1));
    assign sclk_fall = tick && phase_hi;
    assign sclk_rise = tick && !phase_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            phase_hi <= 1'b1;
        end else if (!en) begin
            cnt      <= '0;
            phase_hi <= 1'b1;
        end else if (tick) begin
            cnt      <= '0;
            phase_hi <= !phase_hi;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gsensor_spi_master.sv
// SPI mode-3 master for the ADXL345: single or burst register read/write, header then len bytes, MSB first.
// Latency (1+len)*16*CLK_DIV + 2*CLK_DIV + CS_GAP clocks; write bytes stall with SCLK high until i_wdata_valid.
// Define GSENSOR_SPI_3WIRE_EN to release the SDI pad and sample i_sdi_in during read data bytes.
module gsensor_spi_master
    import gsensor_pkg::*;
#(
    parameter int CLK_DIV = 6,
    parameter int CS_GAP  = 10,
    parameter int MAX_LEN = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [5:0] i_addr,
    input  logic [2:0] i_len,
    input  logic [7:0] i_wdata,
    input  logic       i_wdata_valid,
    output logic       o_wdata_ready,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_cmd_err,
    output logic       o_GSENSOR_CS_n,
    output logic       o_GSENSOR_SCLK,
    output logic       o_sdi_out,
    output logic       o_sdi_oe,
    input  logic       i_sdo,
    input  logic       i_sdi_in
);
    state_t      state, nxt;
    logic [15:0] tmr;
    logic        rw_q, hdr, need_wd;
    logic [2:0]  bit_cnt, byte_cnt;
    logic [7:0]  shreg, rx;
    logic        sclk_fall, sclk_rise, sample, len_ok, last_bit, wd_take;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (state == ST_SHIFT && !need_wd),
        .sclk_fall (sclk_fall),
        .sclk_rise (sclk_rise)
    );

    assign len_ok   = (i_len != 3'd0) && (int'(i_len) <= MAX_LEN);
    assign last_bit = sclk_rise && (bit_cnt == 3'd0);
    // Write data is taken at the byte boundary itself when already valid, so an unstalled write keeps exact timing.
    assign wd_take  = (state == ST_SHIFT) && !rw_q && i_wdata_valid &&
                      (need_wd || (last_bit && byte_cnt != 3'd0));
    assign o_wdata_ready = wd_take;
    assign o_busy        = (state != ST_IDLE);

`ifdef GSENSOR_SPI_3WIRE_EN
    logic sdi_oe, unused_sdo;
    assign sample     = i_sdi_in;
    assign unused_sdo = i_sdo;
    assign o_sdi_oe   = sdi_oe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  sdi_oe <= 1'b1;
        else if (state != ST_SHIFT || nxt == ST_HOLD)  sdi_oe <= 1'b1;
        else if (sclk_fall && !hdr && rw_q)            sdi_oe <= 1'b0;
    end
`else
    logic unused_sdi;
    assign sample     = i_sdo;
    assign unused_sdi = i_sdi_in;
    assign o_sdi_oe   = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (i_start && len_ok)             nxt = ST_SETUP;
            ST_SETUP: if (tmr == '0)                     nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit && byte_cnt == 3'd0)  nxt = ST_HOLD;
            ST_HOLD:  if (tmr == '0)                     nxt = ST_GAP;
            ST_GAP:   if (tmr == '0)                     nxt = ST_IDLE;
            default:                                     nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmr            <= '0;
            rw_q           <= 1'b0;
            hdr            <= 1'b0;
            need_wd        <= 1'b0;
            bit_cnt        <= 3'd7;
            byte_cnt       <= '0;
            shreg          <= '0;
            rx             <= '0;
            o_rdata        <= '0;
            o_rdata_valid  <= 1'b0;
            o_done         <= 1'b0;
            o_cmd_err      <= 1'b0;
            o_GSENSOR_CS_n <= 1'b1;
            o_GSENSOR_SCLK <= 1'b1;
            o_sdi_out      <= 1'b0;
        end else begin
            o_rdata_valid  <= 1'b0;
            o_cmd_err      <= (state == ST_IDLE) && i_start && !len_ok;
            o_done         <= (state == ST_HOLD) && (nxt == ST_GAP);
            o_GSENSOR_CS_n <= !(nxt == ST_SETUP || nxt == ST_SHIFT || nxt == ST_HOLD);

            if (state != nxt) begin
                case (nxt)
                    ST_SETUP, ST_HOLD: tmr <= 16'(CLK_DIV - 1);
                    ST_GAP:            tmr <= 16'(CS_GAP - 1);
                    default:           tmr <= '0;
                endcase
            end else if (tmr != '0) begin
                tmr <= tmr - 16'd1;
            end

            if (state == ST_IDLE && nxt == ST_SETUP) begin
                rw_q     <= i_rw;
                hdr      <= 1'b1;
                need_wd  <= 1'b0;
                bit_cnt  <= 3'd7;
                byte_cnt <= i_len;
                shreg    <= make_hdr(i_rw, i_len != 3'd1, i_addr);
            end

            if (sclk_fall) begin
                o_GSENSOR_SCLK <= 1'b0;
                o_sdi_out      <= shreg[7];
                shreg          <= {shreg[6:0], 1'b0};
            end

            if (sclk_rise) begin
                o_GSENSOR_SCLK <= 1'b1;
                rx             <= {rx[6:0], sample};
                bit_cnt        <= bit_cnt - 3'd1;
                if (bit_cnt == 3'd0) begin
                    hdr <= 1'b0;
                    if (!hdr && rw_q) begin
                        o_rdata       <= {rx[6:0], sample};
                        o_rdata_valid <= 1'b1;
                    end
                    if (byte_cnt != 3'd0) begin
                        byte_cnt <= byte_cnt - 3'd1;
                        if (!rw_q && !i_wdata_valid) need_wd <= 1'b1;
                    end
                end
            end

            if (need_wd && i_wdata_valid) need_wd <= 1'b0;
            if (wd_take)                  shreg   <= i_wdata;
        end
    end

endmodule

// File: doc/gsensor_spi_master.md
Name: gsensor_spi_master

Overview:
SPI initiator for the on-board 3-axis accelerometer (ADXL345-class device, SPI mode 3). It converts single-register or burst register read/write commands from the controller logic into CS_n/SCLK/SDI/SDO activity. It sits between the game-controller core and the GSENSOR pins. The top level owns the tristate buffer; this block drives the data and output-enable separately.

Parameters:
CLK_DIV, 6, system clocks per SCLK half-period (50 MHz/12 = 4.17 MHz; must be >=2)
CS_GAP, 10, minimum system clocks CS_n stays high between transactions
MAX_LEN, 6, maximum burst length in bytes (covers DATAX0..DATAZ1)

Ports:
i_clk  in  1  system clock (50 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  command strobe, sampled only in IDLE
i_rw  in  1  1=read, 0=write
i_addr  in  6  register address
i_len  in  3  byte count, 1..MAX_LEN
i_wdata  in  8  write byte
i_wdata_valid  in  1  i_wdata is valid
o_wdata_ready  out  1  one-cycle pulse: i_wdata consumed this cycle
o_rdata  out  8  read byte
o_rdata_valid  out  1  one-cycle pulse per received byte
o_busy  out  1  transaction in progress, including the CS gap
o_done  out  1  one-cycle pulse after CS_n deasserts
o_cmd_err  out  1  one-cycle pulse: illegal i_len, command dropped
o_GSENSOR_CS_n  out  1  chip select, active low
o_GSENSOR_SCLK  out  1  serial clock, idles high
o_sdi_out  out  1  serial data to the device, MSB first
o_sdi_oe  out  1  output enable for the SDI pad
i_sdo  in  1  serial data from the device (4-wire)
i_sdi_in  in  1  SDI pad readback (3-wire)

Behaviour:
- Reset: CS_n=1, SCLK=1, sdi_out=0, sdi_oe=1, busy=0, all pulses=0, rdata=0. Reset takes effect asynchronously mid-transaction. The FSM returns to IDLE and the partial transaction is abandoned.
- Synchronous deassertion of reset is handled at the top level. This block only requires async assert.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: when i_start=1 and 1<=i_len<=MAX_LEN, latch rw/addr/len and assert busy. Go to SETUP.
- IDLE, illegal length: when i_start=1 with i_len=0 or i_len>MAX_LEN, pulse o_cmd_err and stay in IDLE.
- i_start while busy is ignored.
- SETUP: CS_n=0 for CLK_DIV clocks with SCLK high. Load the header byte {rw, mb=(len>1), addr[5:0]}.
- SHIFT, clocking: a half-period tick fires every CLK_DIV clocks. Falling edge: drive the next bit. Rising edge: sample SDO.
- SHIFT, framing: 8 header bits, then len data bytes, MSB first. A byte counter counts down from len and a bit counter runs 7..0.
- Write data handshake: at each byte boundary before a write data byte, the block waits with SCLK held high until i_wdata_valid=1. It then loads i_wdata and pulses o_wdata_ready in the same cycle. This stall is legal for the device.
- Read data: on the 8th rising edge of each data byte, o_rdata updates and o_rdata_valid pulses the next clock. During the header, sampled bits are discarded.
- HOLD: after the last rising edge, keep SCLK high and CS_n=0 for CLK_DIV clocks. Then set CS_n=1 and pulse o_done.
- GAP: CS_n high for CS_GAP clocks with busy=1, then go to IDLE.
- Latency: one byte is 16*CLK_DIV clocks. A full transaction takes (1+len)*16*CLK_DIV + 2*CLK_DIV + CS_GAP clocks, plus any write stalls.
- sdi_oe is 1 throughout in 4-wire mode.

Optional Feature:
- Macro GSENSOR_SPI_3WIRE_EN.
- When defined: during read data bytes, o_sdi_oe=0 from the falling edge after header bit 0 until HOLD. Read bits are sampled from i_sdi_in, and i_sdo is ignored.
- When undefined: o_sdi_oe is constant 1 and reads sample i_sdo. i_sdi_in is unused.

Decomposition:
- Shared package gsensor_pkg holds:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - header bit positions (RW=7, MB=6)
  - ADXL345 register constants: DEVID=0x00, POWER_CTL=0x2D, DATA_FORMAT=0x31, DATAX0=0x32
- One sub-module, spi_clk_gen: CLK_DIV tick counter that emits sclk_fall/sclk_rise strobes, enabled only in SHIFT.

Test Plan:
- Read DEVID: i_rw=1, addr=0x00, len=1; slave model returns 0xE5 -> header 0x80 on SDI, one rdata_valid with 0xE5, 16 falling edges, o_done pulses once.
- Write POWER_CTL: rw=0, addr=0x2D, len=1, wdata=0x08 -> SDI bits 0x2D then 0x08, one wdata_ready pulse, SCLK high before CS_n falls and after it rises.
- Burst read: rw=1, addr=0x32, len=6; model returns 0x11..0x66 -> header 0xF2 (MB set), six rdata_valid pulses in order, CS_n low continuously.
- Write stall: rw=0, len=2, second i_wdata_valid delayed 50 clocks -> SCLK held high through the stall, no extra edges, data correct.
- Errors and reset: i_len=0 -> o_cmd_err pulse, CS_n stays high; i_rst_n low mid-burst -> CS_n=1 and SCLK=1 immediately, busy=0, next command completes normally.
- 3-wire (macro defined): rw=1 read -> sdi_oe drops after header bit 0, data sampled from i_sdi_in, i_sdo toggling has no effect.
